// File: rtl/cle_pin_serializer.sv
// cle_pin_serializer
//   Pin-reduction front end for the CLE labeling core. A single parallel memory
//   request (ROM read, SRAM read or SRAM write) is accepted at a time. It is sent
//   off-chip as 1-bit serial frames, MSB first. Dtype_o names the stream that is
//   active in each cycle. An SRAM write ends with a one-cycle active-low
//   sram_wen_o pulse. A read ends with a one-cycle rsp_valid pulse, and the
//   captured data is returned on rsp_data. Every output is registered.
//
// Ports
//   clk, reset          clock (posedge) and synchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only while idle
//   req_type            1=ROM read, 2=SRAM read, 3=SRAM write, 0=dropped
//   req_addr, req_data  request address (ROM uses the low ROM_AW bits) and write data
//   rsp_valid, rsp_data read response pulse and captured data (held until next read)
//   rom_q_o, sram_q_o   read-back pins from the external ROM / SRAM
//   rom_a_o, sram_a_o   serial ROM / SRAM address streams
//   sram_d_o            serial SRAM write-data stream
//   sram_wen_o          SRAM write enable, active low
//   Dtype_o             active stream: 0=idle, 1=rom_a, 2=sram_a, 3=sram_d
module cle_pin_serializer #(
  parameter int unsigned ROM_AW   = 7,
  parameter int unsigned SRAM_AW  = 10,
  parameter int unsigned DW       = 8,
  parameter int unsigned SQW      = 7,
  parameter int unsigned PAD_BITS = 2,
  parameter int unsigned RD_WAIT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_type,
  input  logic [SRAM_AW-1:0] req_addr,
  input  logic [DW-1:0]      req_data,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_data,
  input  logic [DW-1:0]      rom_q_o,
  input  logic [SQW-1:0]     sram_q_o,
  output logic               rom_a_o,
  output logic               sram_a_o,
  output logic               sram_d_o,
  output logic               sram_wen_o,
  output logic [1:0]         Dtype_o
);

  localparam int unsigned MAXN = (SRAM_AW > DW) ? SRAM_AW : DW;
  localparam int unsigned CW   = $clog2(MAXN + 1);

  localparam logic [1:0] T_ROM  = 2'd1;
  localparam logic [1:0] T_SRD  = 2'd2;
  localparam logic [1:0] T_WR   = 2'd3;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_ROM  = 2'd1;
  localparam logic [1:0] D_SRAM = 2'd2;
  localparam logic [1:0] D_DATA = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SH_DATA, S_SH_ADDR, S_PAD, S_WAIT, S_WRITE, S_CAPT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;

  // Latched request; the address and data registers double as shift registers
  // whose MSB is always the next serial bit.
  logic [1:0]          r_type;
  logic [SRAM_AW-1:0]  r_addr;
  logic [DW-1:0]       r_data;

  logic                r_ready;
  logic                r_rsp_valid;
  logic [DW-1:0]       r_rsp_data;
  logic                r_rom_a;
  logic                r_sram_a;
  logic                r_sram_d;
  logic                r_wen;
  logic [1:0]          r_dtype;

  logic                w_is_rom;
  logic                w_is_wr;
  logic                w_accept;
  logic                w_shift_d;
  logic                w_shift_a;
  logic                w_capture;
  logic [1:0]          w_dtype_nxt;
  logic                w_rom_a_nxt;
  logic                w_sram_a_nxt;
  logic                w_sram_d_nxt;
  logic                w_wen_nxt;
  logic                w_rsp_valid_nxt;

  assign w_is_rom = (r_type == T_ROM);
  assign w_is_wr  = (r_type == T_WR);

  // The pin values computed here are the ones that appear after the next edge,
  // so every output is a flop, and each frame starts one cycle after accept.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CW'(1);
    w_accept        = 1'b0;
    w_shift_d       = 1'b0;
    w_shift_a       = 1'b0;
    w_capture       = 1'b0;
    w_dtype_nxt     = D_IDLE;
    w_rom_a_nxt     = 1'b0;
    w_sram_a_nxt    = 1'b0;
    w_sram_d_nxt    = 1'b0;
    w_wen_nxt       = 1'b1;
    w_rsp_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_ready && req_valid) begin
          w_accept = 1'b1;
          case (req_type)
            T_WR:         w_state_nxt = S_SH_DATA;
            T_ROM, T_SRD: w_state_nxt = S_SH_ADDR;
            default:      w_state_nxt = S_IDLE;  // type 0 is swallowed
          endcase
        end
      end
      S_SH_DATA: begin
        w_dtype_nxt  = D_DATA;
        w_sram_d_nxt = r_data[DW-1];
        w_shift_d    = 1'b1;
        if (r_cnt == CW'(DW - 1)) begin
          w_state_nxt = S_SH_ADDR;
          w_cnt_nxt   = '0;
        end
      end
      S_SH_ADDR: begin
        w_shift_a = 1'b1;
        if (w_is_rom) begin
          w_dtype_nxt = D_ROM;
          w_rom_a_nxt = r_addr[SRAM_AW-1];
          if (r_cnt == CW'(ROM_AW - 1)) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_dtype_nxt  = D_SRAM;
          w_sram_a_nxt = r_addr[SRAM_AW-1];
          if (r_cnt == CW'(SRAM_AW - 1)) begin
            w_state_nxt = S_PAD;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_PAD: begin
        // Keeps Dtype at 2 with zero data so the SRAM frame is one contiguous run.
        w_dtype_nxt = D_SRAM;
        if (r_cnt == CW'(PAD_BITS - 1)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        // Dtype back to 0 so the external shift counter sees a frame boundary.
        if (r_cnt == CW'(RD_WAIT - 1)) begin
          w_state_nxt = w_is_wr ? S_WRITE : S_CAPT;
          w_cnt_nxt   = '0;
        end
      end
      S_WRITE: begin
        w_wen_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      S_CAPT: begin
        w_rsp_valid_nxt = 1'b1;
        w_capture       = 1'b1;
        w_state_nxt     = S_IDLE;
        w_cnt_nxt       = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rom_a     <= 1'b0;
      r_sram_a    <= 1'b0;
      r_sram_d    <= 1'b0;
      r_wen       <= 1'b1;
      r_dtype     <= D_IDLE;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // Ready rises one cycle after the closing pulse, not together with it.
      r_ready     <= (r_state == S_IDLE) && (w_state_nxt == S_IDLE);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rom_a     <= w_rom_a_nxt;
      r_sram_a    <= w_sram_a_nxt;
      r_sram_d    <= w_sram_d_nxt;
      r_wen       <= w_wen_nxt;
      r_dtype     <= w_dtype_nxt;
      if (w_capture) begin
        r_rsp_data <= w_is_rom ? rom_q_o : {{(DW - SQW){1'b0}}, sram_q_o};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_type <= req_type;
      // ROM addresses are left-aligned so both address streams shift out of the MSB.
      r_addr <= (req_type == T_ROM) ?
                {req_addr[ROM_AW-1:0], {(SRAM_AW - ROM_AW){1'b0}}} : req_addr;
      r_data <= req_data;
    end else begin
      if (w_shift_d) r_data <= {r_data[DW-2:0], 1'b0};
      if (w_shift_a) r_addr <= {r_addr[SRAM_AW-2:0], 1'b0};
    end
  end

  assign req_ready  = r_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rom_a_o    = r_rom_a;
  assign sram_a_o   = r_sram_a;
  assign sram_d_o   = r_sram_d;
  assign sram_wen_o = r_wen;
  assign Dtype_o    = r_dtype;

endmodule

// File: tb/tb_cle_pin_serializer.sv
module tb_cle_pin_serializer;

  localparam int ROM_AW   = 7;
  localparam int SRAM_AW  = 10;
  localparam int DW       = 8;
  localparam int SQW      = 7;
  localparam int PAD_BITS = 2;
  localparam int RD_WAIT  = 2;
  localparam int LAT_ROM  = ROM_AW + RD_WAIT + 1;
  localparam int LAT_SRD  = SRAM_AW + PAD_BITS + RD_WAIT + 1;
  localparam int LAT_WR   = DW + SRAM_AW + PAD_BITS + RD_WAIT + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [1:0]   req_type = 2'd0;
  logic [9:0]   req_addr = 10'd0;
  logic [7:0]   req_data = 8'd0;
  logic         req_ready;
  logic         rsp_valid;
  logic [7:0]   rsp_data;
  logic [7:0]   rom_q_o;
  logic [6:0]   sram_q_o;
  logic         rom_a_o, sram_a_o, sram_d_o, sram_wen_o;
  logic [1:0]   Dtype_o;

  always #5 clk = ~clk;

  cle_pin_serializer #(
    .ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .DW(DW), .SQW(SQW),
    .PAD_BITS(PAD_BITS), .RD_WAIT(RD_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_q_o(rom_q_o), .sram_q_o(sram_q_o),
    .rom_a_o(rom_a_o), .sram_a_o(sram_a_o), .sram_d_o(sram_d_o),
    .sram_wen_o(sram_wen_o), .Dtype_o(Dtype_o)
  );

  typedef struct { bit wr; logic [7:0] data; int due; } exp_t;
  typedef struct { logic [1:0] t; logic [11:0] v; } fr_t;

  exp_t exp_q[$];
  fr_t  fr_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference contents (what the memories should hold) and the emulated chips.
  logic [7:0] ref_rom [128];
  logic [7:0] ref_sram[1024];
  logic [7:0] dev_rom [128];
  logic [7:0] dev_sram[1024];

  logic [1:0]  cur_t = 2'd0;
  int          run_len = 0;
  logic [15:0] sh = 16'd0;
  bit          seen_frame = 1'b0;
  bit          abort_run = 1'b0;
  logic [6:0]  dev_rom_addr = 7'd0;
  logic [9:0]  dev_addr = 10'd0;
  logic [7:0]  dev_wdata = 8'd0;

  assign rom_q_o  = dev_rom[dev_rom_addr];
  assign sram_q_o = dev_sram[dev_addr][6:0];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Off-chip side: decodes each Dtype run into a frame and checks it against the
  // frame the reference model predicted for the accepted request.
  task automatic close_run();
    fr_t f;
    int exp_len;
    logic [11:0] val;
    if (abort_run) begin
      abort_run = 1'b0;
      return;
    end
    case (cur_t)
      2'd1:    begin exp_len = ROM_AW;             val = {5'b0, sh[6:0]}; end
      2'd2:    begin exp_len = SRAM_AW + PAD_BITS; val = sh[11:0];        end
      default: begin exp_len = DW;                 val = {4'b0, sh[7:0]}; end
    endcase
    chk("frame_len", 32'(run_len), 32'(exp_len));
    if (fr_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_frame: got frame type %0d bits %0h, expected no frame", cur_t, val);
    end else begin
      f = fr_q.pop_front();
      chk("frame_type", 32'(cur_t), 32'(f.t));
      chk("frame_bits", 32'(val), 32'(f.v));
    end
    case (cur_t)
      2'd1:    dev_rom_addr = sh[6:0];
      2'd2:    dev_addr = sh[11:2];
      default: dev_wdata = sh[7:0];
    endcase
  endtask

  always @(negedge clk) begin
    if (Dtype_o !== cur_t) begin
      if (cur_t != 2'd0) begin
        close_run();
        seen_frame = 1'b1;
      end else if (seen_frame) begin
        chk("gap_ge_rdwait", 32'(run_len >= RD_WAIT), 32'd1);
      end
      cur_t = Dtype_o;
      run_len = 0;
      sh = 16'd0;
    end
    run_len++;
    case (Dtype_o)
      2'd1:    sh = {sh[14:0], rom_a_o};
      2'd2:    sh = {sh[14:0], sram_a_o};
      2'd3:    sh = {sh[14:0], sram_d_o};
      default: ;
    endcase
    chk("unselected_pins_zero",
        32'((Dtype_o != 2'd1 && rom_a_o) || (Dtype_o != 2'd2 && sram_a_o) ||
            (Dtype_o != 2'd3 && sram_d_o)), 32'd0);
    if (sram_wen_o === 1'b0) dev_sram[dev_addr] = dev_wdata;
  end

  // Scoreboard monitor: every rsp_valid or wen pulse must match the oldest pending request.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 || sram_wen_o === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got rsp_valid=%b wen=%b at cycle %0d, expected no pulse",
                 rsp_valid, sram_wen_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(mon_e.due));
        chk("pulse_wen", 32'(sram_wen_o), mon_e.wr ? 32'd0 : 32'd1);
        chk("pulse_rsp_valid", 32'(rsp_valid), mon_e.wr ? 32'd0 : 32'd1);
        if (!mon_e.wr) chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end
    end
  end

  task automatic issue(input logic [1:0] t, input logic [9:0] a, input logic [7:0] d);
    int acc;
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_data  = d;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_ready_timeout: got req_ready=%b after 100 cycles, expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_type  = 2'($urandom_range(0, 3));
    req_addr  = 10'($urandom_range(0, 1023));
    req_data  = 8'($urandom_range(0, 255));
    case (t)
      2'd1: begin
        fr_q.push_back('{2'd1, {5'b0, a[6:0]}});
        exp_q.push_back('{1'b0, ref_rom[a[6:0]], acc + LAT_ROM});
      end
      2'd2: begin
        fr_q.push_back('{2'd2, {a, 2'b00}});
        exp_q.push_back('{1'b0, {1'b0, ref_sram[a][6:0]}, acc + LAT_SRD});
      end
      2'd3: begin
        fr_q.push_back('{2'd3, {4'b0, d}});
        fr_q.push_back('{2'd2, {a, 2'b00}});
        ref_sram[a] = d;
        exp_q.push_back('{1'b1, 8'h00, acc + LAT_WR});
      end
      default: ;
    endcase
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_Dtype"},     32'(Dtype_o),    32'd0);
    chk({tag, "_wen"},       32'(sram_wen_o), 32'd1);
    chk({tag, "_req_ready"}, 32'(req_ready),  32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid),  32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),   32'd0);
    chk({tag, "_pins"},      32'({rom_a_o, sram_a_o, sram_d_o}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] saved;
    int guard;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom_range(0, 255));
      ref_rom[i] = v;
      dev_rom[i] = v;
    end
    for (int i = 0; i < 1024; i++) begin
      v = 8'($urandom_range(0, 255));
      ref_sram[i] = v;
      dev_sram[i] = v;
    end
    ref_rom[7'h55] = 8'hA3;
    dev_rom[7'h55] = 8'hA3;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_vals("idle");

    issue(2'd1, 10'h055, 8'h00);
    issue(2'd3, 10'h3FF, 8'h81);
    issue(2'd2, 10'h3FF, 8'h00);
    for (int i = 0; i < 4; i++) issue(2'd3, 10'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) issue(2'd2, 10'(i), 8'h00);

    issue(2'd0, 10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
    @(negedge clk);
    chk("illegal_req_ready", 32'(req_ready), 32'd1);
    chk("illegal_Dtype", 32'(Dtype_o), 32'd0);

    // Abort a write mid-stream with reset; memory must stay untouched.
    saved = ref_sram[10'h155];
    issue(2'd3, 10'h155, 8'h5A);
    repeat (5) @(posedge clk);
    @(negedge clk);
    abort_run = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("abort");
    reset = 1'b0;
    exp_q.delete();
    fr_q.delete();
    ref_sram[10'h155] = saved;
    repeat (30) @(negedge clk);
    issue(2'd2, 10'h155, 8'h00);
    issue(2'd1, 10'($urandom_range(0, 1023)), 8'h00);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] t;
      logic [9:0] a;
      t = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      issue(t, a, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("frames_drained", 32'(fr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
